// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcodes, instruction field positions and fetch FSM state type
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JIDX_MSB   = 25;
  localparam int JIDX_LSB   = 0;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    FETCH      = 2'd1,
    HOLD       = 2'd2
  } fetch_state_t;

  // Word offset of a branch: sign-extended immediate scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - sequential / branch / jump target select for the fetch unit
module pc_next_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [5:0]  opcode;
  logic [15:0] imm16;
  logic [25:0] jidx;
  logic [31:0] jump_target;
  logic [31:0] branch_target;

  assign opcode = ir[OPCODE_MSB:OPCODE_LSB];
  assign imm16  = ir[IMM_MSB:IMM_LSB];
  assign jidx   = ir[JIDX_MSB:JIDX_LSB];

  assign pc_plus4      = pc + 32'd4;
  assign jump_target   = {pc_plus4[31:28], jidx, 2'b00};
  assign branch_target = pc_plus4 + branch_offset(imm16);

  // Jump wins over a taken branch; Branch is trusted as-is from control_unit.
  always_comb begin
    next_pc = pc_plus4;
    if (opcode == OP_J) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC/IR holder with imem req/ready fetch FSM feeding control_unit
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              Branch,
  input  logic              Zero,
  output logic [5:0]        Opcode,
  output logic [4:0]        Rs,
  output logic [4:0]        Rt,
  output logic [4:0]        Rd,
  output logic [5:0]        Funct,
  output logic [15:0]       Imm16,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PC_plus4
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [31:0]       next_pc;
  logic [31:0]       pc_plus4;

  pc_next_logic u_pc_next (
    .pc       (pc),
    .ir       (ir),
    .branch   (Branch),
    .zero     (Zero),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  // Outputs decode straight from state so an async reset drops req/valid at once.
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == HOLD);
  assign imem_addr   = pc;
  assign PC          = pc;
  assign PC_plus4    = pc_plus4;

  assign Opcode = ir[OPCODE_MSB:OPCODE_LSB];
  assign Rs     = ir[RS_MSB:RS_LSB];
  assign Rt     = ir[RT_MSB:RT_LSB];
  assign Rd     = ir[RD_MSB:RD_LSB];
  assign Funct  = ir[FUNCT_MSB:FUNCT_LSB];
  assign Imm16  = ir[IMM_MSB:IMM_LSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_WAIT;
      pc    <= RESET_PC;
      ir    <= 32'h0;
    end else begin
      case (state)
        RESET_WAIT: state <= FETCH;
        FETCH: begin
          if (imem_ready) begin
            ir    <= imem_rdata;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        default: state <= RESET_WAIT;
      endcase
    end
  end

  // A misaligned RESET_PC is a configuration error and shows up here.
  a_pc_aligned: assert property (@(posedge clk) disable iff (!rst_n) pc[1:0] == 2'b00);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic [5:0]  Opcode;
  logic [4:0]  Rs, Rt, Rd;
  logic [5:0]  Funct;
  logic [15:0] Imm16;
  logic [31:0] PC, PC_plus4;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .Branch(Branch), .Zero(Zero),
    .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Funct(Funct), .Imm16(Imm16),
    .PC(PC), .PC_plus4(PC_plus4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference next-PC from the architectural rules, using integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                           input logic br, input logic zr);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    if (w[31:26] == 6'd2) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (br && zr) begin
      off = int'($signed(w[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic check_fields(input logic [31:0] w);
    chk("valid", instr_valid, 1);
    chk("opcode", Opcode, w[31:26]);
    chk("rs", Rs, w[25:21]);
    chk("rt", Rt, w[20:16]);
    chk("rd", Rd, w[15:11]);
    chk("funct", Funct, w[5:0]);
    chk("imm16", Imm16, w[15:0]);
    chk("pc", PC, m_pc);
    chk("pc_plus4", PC_plus4, m_pc + 32'd4);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("req_timeout", imem_req, 1);
  endtask

  // Called on a negedge; asserts reset mid-cycle and restarts from RESET_PC.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", PC, RST_PC);
    chk("rst_pc4", PC_plus4, RST_PC + 32'd4);
    chk("rst_opcode", Opcode, 0);
    chk("rst_imm", Imm16, 0);
    imem_ready = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    chk("rst_hold_req", imem_req, 0);
    rst_n = 1'b1;
    m_pc = RST_PC;
    @(negedge clk);
    chk("rw_to_fetch", imem_req, 1);
    chk("first_addr", imem_addr, RST_PC);
  endtask

  task automatic do_fetch(input logic [31:0] w, input int mw);
    wait_req();
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_valid", instr_valid, 0);
    for (int i = 0; i < mw; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      instr_ready = 1'($urandom);
      Branch = 1'($urandom);
      Zero = 1'($urandom);
      @(negedge clk);
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, m_pc);
      chk("stall_valid", instr_valid, 0);
    end
    imem_ready = 1'b1;
    imem_rdata = w;
    instr_ready = 1'($urandom);
    Branch = 1'($urandom);
    Zero = 1'($urandom);
    @(negedge clk);
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
    chk("hold_req", imem_req, 0);
    check_fields(w);
  endtask

  task automatic do_hold(input logic [31:0] w, input int hw, input logic br, input logic zr);
    for (int i = 0; i < hw; i++) begin
      instr_ready = 1'b0;
      Branch = 1'($urandom);
      Zero = 1'($urandom);
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      @(negedge clk);
      chk("bp_req", imem_req, 0);
      check_fields(w);
    end
    instr_ready = 1'b1;
    Branch = br;
    Zero = zr;
    @(negedge clk);
    instr_ready = 1'b0;
    Branch = 1'b0;
    Zero = 1'b0;
    imem_ready = 1'b0;
    m_pc = ref_next(m_pc, w, br, zr);
    chk("adv_valid", instr_valid, 0);
    chk("adv_req", imem_req, 1);
    chk("adv_addr", imem_addr, m_pc);
  endtask

  task automatic run_instr(input logic [31:0] w, input int mw, input int hw,
                           input logic br, input logic zr);
    do_fetch(w, mw);
    do_hold(w, hw, br, zr);
  endtask

  initial begin
    int          c0;
    logic [31:0] w;
    logic [5:0]  ops [6];
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b111111;
    m_pc = RST_PC;

    @(negedge clk);
    do_reset();

    c0 = cyc;
    do_fetch(32'h8C01_0004, 0);
    chk("lw_opcode", Opcode, 6'b100011);
    do_hold(32'h8C01_0004, 0, 1'b0, 1'b0);
    do_fetch(32'hAC01_0008, 0);
    chk("sw_opcode", Opcode, 6'b101011);
    chk("sw_pc", PC, 32'h4);
    do_hold(32'hAC01_0008, 0, 1'b0, 1'b0);
    chk("straight_addr", imem_addr, 32'h8);
    chk("straight_cycles", cyc - c0, 4);

    run_instr(32'h0800_0004, 0, 0, 1'b0, 1'b0);
    chk("j_to_10", imem_addr, 32'h10);
    run_instr(32'h1000_0003, 0, 0, 1'b1, 1'b1);
    chk("beq_taken", imem_addr, 32'h20);
    run_instr(32'h0800_0004, 0, 0, 1'b0, 1'b0);
    run_instr(32'h1000_0003, 0, 0, 1'b1, 1'b0);
    chk("beq_not_taken", imem_addr, 32'h14);
    run_instr(32'h0800_0004, 0, 0, 1'b0, 1'b0);
    run_instr(32'h1000_FFFF, 0, 0, 1'b1, 1'b1);
    chk("beq_self", imem_addr, 32'h10);

    run_instr(32'h0022_1820, 3, 4, 1'b0, 1'b0);
    chk("backpressure_adv", imem_addr, 32'h14);

    run_instr(32'h0BFF_FFFF, 0, 0, 1'b0, 1'b0);
    chk("j_region_top", imem_addr, 32'h0FFF_FFFC);
    run_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0);
    chk("seq_cross", imem_addr, 32'h1000_0000);
    run_instr(32'h0800_0040, 0, 0, 1'b0, 1'b0);
    chk("j_upper_nibble", imem_addr, 32'h1000_0100);

    for (int k = 0; k < 40; k++) begin
      w = $urandom;
      w[31:26] = ops[$urandom_range(0, 5)];
      run_instr(w, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 1'($urandom));
    end

    do_reset();
    run_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b1);
    chk("beq_wrap_back", imem_addr, 32'hFFFF_FFFC);
    run_instr(32'h0000_0020, 0, 1, 1'b0, 1'b0);
    chk("pc_wrap", imem_addr, 32'h0);

    do_fetch(32'h8C01_0004, 0);
    do_reset();
    run_instr(32'hAC01_0008, 1, 1, 1'b0, 1'b0);
    chk("after_reset_adv", imem_addr, RST_PC + 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
